fetch_queue: RTL and testbench

//  Instruction fetch stage directly upstream of the single-cycle 16-bit instruction memory.

---
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Function : PC generator feeding a single-cycle instruction memory, with a
//            DEPTH-entry {pc, instr} FIFO towards decode, redirect and HALT stop.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd1,
  parameter logic [4:0]  HALT_OPC = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  output logic        imem_wr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic [15:0] out_pc_next,
  output logic        halted
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one = 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = 1;

  logic [15:0]        r_pc;
  logic [c_ptr_w:0]   r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic               r_stop;
  logic [15:0]        r_fifo_instr [DEPTH];
  logic [15:0]        r_fifo_pc    [DEPTH];

  logic w_pop;
  logic w_fetch;
  logic w_is_halt;

  assign w_is_halt = (imem_rdata[15:11] == HALT_OPC);
  assign w_pop     = out_valid & out_ready & ~redirect;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign w_fetch   = ~rst & ~redirect & ~r_stop & ((r_count < c_depth) | w_pop);

  assign imem_addr   = r_pc;
  assign imem_en     = w_fetch;
  assign imem_wr     = 1'b0;
  assign out_valid   = ~rst & (r_count != '0);
  assign out_instr   = r_fifo_instr[r_rd_ptr];
  assign out_pc      = r_fifo_pc[r_rd_ptr];
  assign out_pc_next = r_fifo_pc[r_rd_ptr] + PC_INC;
  assign halted      = ~rst & r_stop & (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stop   <= 1'b0;
    end else if (redirect) begin
      r_pc     <= redirect_pc;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stop   <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
        // A HALT word is kept, but the PC stays parked on it.
        if (w_is_halt) r_stop <= 1'b1;
        else           r_pc   <= r_pc + PC_INC;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Function : Self-checking bench for fetch_queue: directed vector table, halt
//            and PC-wrap sequences, then random traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int c_depth = 4;

  logic        clk = 1'b0;
  logic        rst, redirect, out_ready;
  logic [15:0] redirect_pc, imem_rdata;
  logic [15:0] imem_addr, out_instr, out_pc, out_pc_next;
  logic        imem_en, imem_wr, out_valid, halted;

  logic [15:0] mem [65536];

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of {pc, instr} plus the fetch PC and stop flag.
  logic [31:0] m_q [$];
  logic [15:0] m_pc;
  bit          m_stop;

  typedef struct {
    logic        rst, rdy, redir;
    logic [15:0] rpc;
    logic        en;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc, instr;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_queue #(.DEPTH(c_depth)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_wr(imem_wr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .halted(halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc,
                             input logic en, input logic [15:0] addr, input logic val,
                             input logic [15:0] pc, input logic [15:0] instr);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.redir = rd; t.rpc = rpc; t.en = en;
    t.addr = addr; t.valid = val; t.pc = pc; t.instr = instr;
    return t;
  endfunction

  function automatic bit model_fetch();
    bit pop = (m_q.size() != 0) && out_ready && !redirect;
    return !rst && !redirect && !m_stop && (m_q.size() < c_depth || pop);
  endfunction

  // Advance one clock: update the model from the pre-edge state, return at negedge.
  task automatic tick();
    bit pop, fet;
    logic [31:0] dropped;
    @(posedge clk);
    pop = (m_q.size() != 0) && out_ready && !redirect && !rst;
    fet = model_fetch();
    if (rst) begin
      m_q.delete(); m_pc = 16'h0000; m_stop = 0;
    end else if (redirect) begin
      m_q.delete(); m_pc = redirect_pc; m_stop = 0;
    end else begin
      if (pop) dropped = m_q.pop_front();
      if (fet) begin
        m_q.push_back({m_pc, mem[m_pc]});
        if (mem[m_pc][15:11] == 5'b00000) m_stop = 1;
        else m_pc = m_pc + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    bit exp_valid = !rst && (m_q.size() != 0);
    chk("m_en", 16'(imem_en), 16'(model_fetch()));
    chk("m_addr", imem_addr, m_pc);
    chk("m_wr", 16'(imem_wr), 16'h0);
    chk("m_valid", 16'(out_valid), 16'(exp_valid));
    chk("m_halted", 16'(halted), 16'(!rst && m_stop && m_q.size() == 0));
    if (exp_valid) begin
      chk("m_pc", out_pc, m_q[0][31:16]);
      chk("m_instr", out_instr, m_q[0][15:0]);
      chk("m_pc_next", out_pc_next, m_q[0][31:16] + 16'd1);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc);
    rst = r; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA00A; mem[1] = 16'hB00B; mem[2] = 16'hC00C; mem[3] = 16'hD00D;
    for (int i = 4; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[16'h0040] = 16'h7040; mem[16'h0041] = 16'h7041;
    mem[16'h0010] = 16'h6010; mem[16'hFFFF] = 16'h8FFF;
    m_q.delete(); m_pc = 16'h0000; m_stop = 0;

    rst = 1; out_ready = 0; redirect = 0; redirect_pc = 16'h0;
    @(negedge clk);

    // Reset, streaming fetch, back-pressure, full-queue push+pop, redirect.
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,16'h0,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,16'h1,1,16'h0,16'hA00A));
    tbl.push_back(v(0,1,0,0, 1,16'h2,1,16'h1,16'hB00B));
    tbl.push_back(v(0,1,0,0, 1,16'h3,1,16'h2,16'hC00C));
    tbl.push_back(v(0,1,0,0, 1,16'h4,1,16'h3,16'hD00D));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,16'h0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,16'h1,1,16'h0,16'hA00A));
    tbl.push_back(v(0,0,0,0, 1,16'h2,1,16'h0,16'hA00A));
    tbl.push_back(v(0,0,0,0, 1,16'h3,1,16'h0,16'hA00A));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,0, 0,16'h4,1,16'h0,16'hA00A));
    tbl.push_back(v(0,1,0,0, 1,16'h4,1,16'h0,16'hA00A));
    tbl.push_back(v(0,1,0,0, 1,16'h5,1,16'h1,16'hB00B));
    tbl.push_back(v(0,1,0,0, 1,16'h6,1,16'h2,16'hC00C));
    tbl.push_back(v(0,1,0,0, 1,16'h7,1,16'h3,16'hD00D));
    tbl.push_back(v(0,1,0,0, 1,16'h8,1,16'h4,16'h1004));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,16'h0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,16'h1,1,16'h0,16'hA00A));
    tbl.push_back(v(0,0,0,0, 1,16'h2,1,16'h0,16'hA00A));
    tbl.push_back(v(0,1,1,16'h0040, 0,16'h3,1,16'h0,16'hA00A));
    tbl.push_back(v(0,1,0,0, 1,16'h0040,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,16'h0041,1,16'h0040,16'h7040));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      chk("t_en", 16'(imem_en), 16'(tbl[i].en));
      chk("t_valid", 16'(out_valid), 16'(tbl[i].valid));
      chk("t_wr", 16'(imem_wr), 16'h0);
      if (tbl[i].rst) chk("t_halted", 16'(halted), 16'h0);
      else            chk("t_addr", imem_addr, tbl[i].addr);
      if (tbl[i].valid) begin
        chk("t_pc", out_pc, tbl[i].pc);
        chk("t_instr", out_instr, tbl[i].instr);
        chk("t_pc_next", out_pc_next, tbl[i].pc + 16'd1);
      end
      tick();
    end

    // HALT at pc 5, drain, then redirect resumes fetch.
    mem[5] = 16'h0000;
    drive(1,0,0,0); tick();
    drive(1,0,0,0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, i == 8, 16'h0010);
      check_model();
      if (i == 6) begin
        chk("halt_en", 16'(imem_en), 16'h0);
        chk("halt_addr", imem_addr, 16'h0005);
        chk("halt_head", out_pc, 16'h0005);
        chk("halt_early", 16'(halted), 16'h0);
      end
      if (i == 7) chk("halted", 16'(halted), 16'h1);
      if (i == 9) begin
        chk("resume_halted", 16'(halted), 16'h0);
        chk("resume_addr", imem_addr, 16'h0010);
        chk("resume_en", 16'(imem_en), 16'h1);
      end
      tick();
    end
    mem[5] = 16'h1005;

    // PC wrap from FFFF to 0000.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i == 0, 16'hFFFF);
      check_model();
      if (i == 1) chk("wrap_addr0", imem_addr, 16'hFFFF);
      if (i == 2) begin
        chk("wrap_addr1", imem_addr, 16'h0000);
        chk("wrap_pc", out_pc, 16'hFFFF);
        chk("wrap_pc_next", out_pc_next, 16'h0000);
      end
      tick();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 100) < 6,
            (($urandom % 4) == 0) ? 16'hFFFD + 16'($urandom % 3) : 16'($urandom));
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
